// File: rtl/ex_pkg.sv
// ---------------------------------------------------------------------------
// ex_pkg
// Shared definitions for the execute stage:
//   - DATA_W / ADDR_W widths
//   - alu_sel operation-class constants
//   - alu_op operation-code constants
//   - divider FSM state enum
//   - small two's-complement helper used by the divider sign fix-up
// ---------------------------------------------------------------------------
package ex_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Operation classes carried on alu_sel
    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_DIV   = 3'b110;

    // LOGIC class codes
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;

    // SHIFT class codes
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;

    // ARITH class codes
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUB  = 8'h22;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;

    // DIV class codes
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    // Divider sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } div_state_e;

    // Conditionally two's-complement a value (magnitude <-> signed form)
    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
        logic [DATA_W-1:0] r;
        r = neg ? ((~v) + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
        return r;
    endfunction

endpackage

// File: rtl/ex_stage_div_div_iter.sv
// ---------------------------------------------------------------------------
// div_iter
// Iterative 32-step restoring divider with signed/unsigned support.
// Owns the IDLE/BUSY/DONE FSM, the step counter and the
// remainder/quotient/divisor registers plus the final sign fix-up.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   flush            abort: FSM returns to IDLE on the next edge
//   start            a valid DIV/DIVU is presented in this cycle
//   is_signed        1 = DIV, 0 = DIVU (sampled with start)
//   dividend/divisor operands (sampled only on leaving IDLE)
//   stall_req        combinational: divide occupying the stage
//   done             combinational: result valid this cycle (DONE state)
//   quotient         signed-corrected quotient, valid with done
//   remainder        signed-corrected remainder, valid with done
// ---------------------------------------------------------------------------
module div_iter
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    div_state_e        state_r;
    logic [4:0]        cnt_r;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] dvs_r;
    logic              q_neg_r;
    logic              r_neg_r;

    logic [DATA_W-1:0] a_mag_s;
    logic [DATA_W-1:0] b_mag_s;
    logic [DATA_W:0]   trial_s;
    logic [DATA_W:0]   diff_s;
    logic              take_s;
    logic              div_zero_s;

    // Operand magnitudes and one restoring step. The partial remainder is
    // always below the divisor, so trial - divisor fits in DATA_W+1 bits
    // and the top bit is a valid borrow/sign.
    always_comb begin
        a_mag_s    = neg_if(dividend, is_signed & dividend[DATA_W-1]);
        b_mag_s    = neg_if(divisor,  is_signed & divisor[DATA_W-1]);
        div_zero_s = (divisor == {DATA_W{1'b0}});
        trial_s    = {rem_r, quo_r[DATA_W-1]};
        diff_s     = trial_s - {1'b0, dvs_r};
        take_s     = ~diff_s[DATA_W];
    end

    // Divider FSM: state, counter and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            rem_r   <= {DATA_W{1'b0}};
            quo_r   <= {DATA_W{1'b0}};
            dvs_r   <= {DATA_W{1'b0}};
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (flush) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= 5'd0;
                    if (start) begin
                        if (div_zero_s) begin
                            // Divide by zero: all-ones quotient, raw dividend
                            // as remainder, no sign correction.
                            state_r <= DONE;
                            quo_r   <= {DATA_W{1'b1}};
                            rem_r   <= dividend;
                            q_neg_r <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            // Dividend magnitude is shifted out of quo_r MSB
                            // first while quotient bits shift in at the LSB.
                            state_r <= BUSY;
                            quo_r   <= a_mag_s;
                            rem_r   <= {DATA_W{1'b0}};
                            dvs_r   <= b_mag_s;
                            q_neg_r <= is_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                            r_neg_r <= is_signed & dividend[DATA_W-1];
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    rem_r <= take_s ? diff_s[DATA_W-1:0] : trial_s[DATA_W-1:0];
                    quo_r <= {quo_r[DATA_W-2:0], take_s};
                    if (cnt_r == 5'd31) begin
                        state_r <= DONE;
                        cnt_r   <= 5'd0;
                    end else begin
                        state_r <= BUSY;
                        cnt_r   <= cnt_r + 5'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    cnt_r   <= 5'd0;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 5'd0;
                end
            endcase
        end
    end

    // Stall/done strobes and signed result correction
    always_comb begin
        stall_req = ~reset & ~flush &
                    (((state_r == IDLE) & start) | (state_r == BUSY));
        done      = ~reset & ~flush & (state_r == DONE);
        quotient  = neg_if(quo_r, q_neg_r);
        remainder = neg_if(rem_r, r_neg_r);
    end

endmodule

// File: rtl/ex_stage_div.sv
// ---------------------------------------------------------------------------
// ex_stage_div
// Execute stage: single-cycle LOGIC/SHIFT/ARITH ALU plus an iterative
// DIV/DIVU unit (div_iter). Results land in a registered EX/MEM bank.
//
// Optional build macro: OVERFLOW_TRAP_EN
//   defined   - signed ADD/SUB overflow suppresses ex_wr_en and raises ex_ovf
//   undefined - ex_ovf port absent, ADD/SUB behave as ADDU/SUBU
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   alu_sel, alu_op       operation class and code from ID/EX
//   src_data1, src_data2  operands (SHIFT: amount in src_data1[4:0],
//                         data in src_data2)
//   wr_addr, wr_en        destination register and write enable
//   flush                 annul current instruction, abort any divide
//   stall_req             divide occupying the stage (combinational)
//   ex_wr_addr/en/data    registered register-file write
//   ex_hilo_we, ex_hi/lo  registered HI/LO write (remainder/quotient)
//   ex_ovf                registered overflow flag (OVERFLOW_TRAP_EN only)
// ---------------------------------------------------------------------------
module ex_stage_div
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        alu_sel,
    input  logic [7:0]        alu_op,
    input  logic [DATA_W-1:0] src_data1,
    input  logic [DATA_W-1:0] src_data2,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_en,
    input  logic              flush,
    output logic              stall_req,
    output logic [ADDR_W-1:0] ex_wr_addr,
    output logic              ex_wr_en,
    output logic [DATA_W-1:0] ex_wr_data,
    output logic              ex_hilo_we,
    output logic [DATA_W-1:0] ex_hi,
`ifdef OVERFLOW_TRAP_EN
    output logic [DATA_W-1:0] ex_lo,
    output logic              ex_ovf
`else
    output logic [DATA_W-1:0] ex_lo
`endif
);

    logic              div_start_s;
    logic              div_signed_s;
    logic              div_done_s;
    logic [DATA_W-1:0] quotient_s;
    logic [DATA_W-1:0] remainder_s;

    logic [DATA_W-1:0] sum_s;
    logic [DATA_W-1:0] diff_s;
    logic [4:0]        shamt_s;
    logic [DATA_W-1:0] sra_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_wr_en_s;

    // Only recognised divide codes start the divider; other DIV-class codes
    // fall through to the ALU path as unknown operations.
    always_comb begin
        div_start_s  = (alu_sel == SEL_DIV) &
                       ((alu_op == OP_DIV) | (alu_op == OP_DIVU));
        div_signed_s = (alu_op == OP_DIV);
    end

    div_iter u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .start     (div_start_s),
        .is_signed (div_signed_s),
        .dividend  (src_data1),
        .divisor   (src_data2),
        .stall_req (stall_req),
        .done      (div_done_s),
        .quotient  (quotient_s),
        .remainder (remainder_s)
    );

    // Single-cycle ALU; unknown class/code pairs yield zero
    always_comb begin
        sum_s        = src_data1 + src_data2;
        diff_s       = src_data1 - src_data2;
        shamt_s      = src_data1[4:0];
        sra_s        = $unsigned($signed(src_data2) >>> shamt_s);
        alu_result_s = {DATA_W{1'b0}};
        case (alu_sel)
            SEL_LOGIC: begin
                case (alu_op)
                    OP_OR:   alu_result_s = src_data1 | src_data2;
                    OP_AND:  alu_result_s = src_data1 & src_data2;
                    OP_XOR:  alu_result_s = src_data1 ^ src_data2;
                    OP_NOR:  alu_result_s = ~(src_data1 | src_data2);
                    default: alu_result_s = {DATA_W{1'b0}};
                endcase
            end
            SEL_SHIFT: begin
                case (alu_op)
                    OP_SLL:  alu_result_s = src_data2 << shamt_s;
                    OP_SRL:  alu_result_s = src_data2 >> shamt_s;
                    OP_SRA:  alu_result_s = sra_s;
                    default: alu_result_s = {DATA_W{1'b0}};
                endcase
            end
            SEL_ARITH: begin
                case (alu_op)
                    OP_ADD, OP_ADDU: alu_result_s = sum_s;
                    OP_SUB, OP_SUBU: alu_result_s = diff_s;
                    OP_SLT:  alu_result_s = {{(DATA_W-1){1'b0}},
                                             ($signed(src_data1) < $signed(src_data2))};
                    OP_SLTU: alu_result_s = {{(DATA_W-1){1'b0}},
                                             (src_data1 < src_data2)};
                    default: alu_result_s = {DATA_W{1'b0}};
                endcase
            end
            default: alu_result_s = {DATA_W{1'b0}};
        endcase
    end

`ifdef OVERFLOW_TRAP_EN
    logic ovf_s;

    // Signed overflow: like-signed ADD or unlike-signed SUB whose result
    // sign departs from operand A
    always_comb begin
        ovf_s = 1'b0;
        if ((alu_sel == SEL_ARITH) & (alu_op == OP_ADD)) begin
            ovf_s = (src_data1[DATA_W-1] == src_data2[DATA_W-1]) &
                    (sum_s[DATA_W-1] != src_data1[DATA_W-1]);
        end else if ((alu_sel == SEL_ARITH) & (alu_op == OP_SUB)) begin
            ovf_s = (src_data1[DATA_W-1] != src_data2[DATA_W-1]) &
                    (diff_s[DATA_W-1] != src_data1[DATA_W-1]);
        end else begin
            ovf_s = 1'b0;
        end
        alu_wr_en_s = wr_en & ~ovf_s;
    end

    // Overflow flag register, cleared for bubbles and divide results
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ovf <= 1'b0;
        end else if (flush | stall_req | div_done_s) begin
            ex_ovf <= 1'b0;
        end else begin
            ex_ovf <= ovf_s;
        end
    end
`else
    // Without the trap, the write enable passes through unchanged
    always_comb begin
        alu_wr_en_s = wr_en;
    end
`endif

    // EX/MEM output bank. Priority: reset, flush/stall bubble, divide
    // result, ordinary single-cycle result.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_wr_addr <= {ADDR_W{1'b0}};
            ex_wr_en   <= 1'b0;
            ex_wr_data <= {DATA_W{1'b0}};
            ex_hilo_we <= 1'b0;
            ex_hi      <= {DATA_W{1'b0}};
            ex_lo      <= {DATA_W{1'b0}};
        end else if (flush | stall_req) begin
            ex_wr_addr <= {ADDR_W{1'b0}};
            ex_wr_en   <= 1'b0;
            ex_wr_data <= {DATA_W{1'b0}};
            ex_hilo_we <= 1'b0;
            ex_hi      <= {DATA_W{1'b0}};
            ex_lo      <= {DATA_W{1'b0}};
        end else if (div_done_s) begin
            ex_wr_addr <= {ADDR_W{1'b0}};
            ex_wr_en   <= 1'b0;
            ex_wr_data <= {DATA_W{1'b0}};
            ex_hilo_we <= 1'b1;
            ex_hi      <= remainder_s;
            ex_lo      <= quotient_s;
        end else begin
            ex_wr_addr <= wr_addr;
            ex_wr_en   <= alu_wr_en_s;
            ex_wr_data <= alu_result_s;
            ex_hilo_we <= 1'b0;
            ex_hi      <= {DATA_W{1'b0}};
            ex_lo      <= {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_ex_stage_div.sv
`timescale 1ns/1ps
// Self-checking bench for ex_stage_div: directed and randomized ALU ops,
// signed/unsigned divides, divide-by-zero, flush aborts and reset.
module tb_ex_stage_div;

    localparam logic [2:0] S_NOP = 3'b000, S_LOGIC = 3'b001, S_SHIFT = 3'b010,
                           S_ARITH = 3'b100, S_DIV = 3'b110;
    localparam logic [7:0] O_OR = 8'h25, O_AND = 8'h24, O_XOR = 8'h26, O_NOR = 8'h27,
                           O_SLL = 8'h7C, O_SRL = 8'h02, O_SRA = 8'h03,
                           O_ADD = 8'h20, O_ADDU = 8'h21, O_SUB = 8'h22, O_SUBU = 8'h23,
                           O_SLT = 8'h2A, O_SLTU = 8'h2B, O_DIV = 8'h1A, O_DIVU = 8'h1B;

    logic        clk;
    logic        reset;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_op;
    logic [31:0] src_data1;
    logic [31:0] src_data2;
    logic [4:0]  wr_addr;
    logic        wr_en;
    logic        flush;
    logic        stall_req;
    logic [4:0]  ex_wr_addr;
    logic        ex_wr_en;
    logic [31:0] ex_wr_data;
    logic        ex_hilo_we;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
`ifdef OVERFLOW_TRAP_EN
    logic        ex_ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    ex_stage_div dut (
        .clk        (clk),
        .reset      (reset),
        .alu_sel    (alu_sel),
        .alu_op     (alu_op),
        .src_data1  (src_data1),
        .src_data2  (src_data2),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .flush      (flush),
        .stall_req  (stall_req),
        .ex_wr_addr (ex_wr_addr),
        .ex_wr_en   (ex_wr_en),
        .ex_wr_data (ex_wr_data),
        .ex_hilo_we (ex_hilo_we),
        .ex_hi      (ex_hi),
`ifdef OVERFLOW_TRAP_EN
        .ex_lo      (ex_lo),
        .ex_ovf     (ex_ovf)
`else
        .ex_lo      (ex_lo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [7:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] ad, input logic en);
        alu_sel = s; alu_op = o; src_data1 = a; src_data2 = b; wr_addr = ad; wr_en = en;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [2:0] s, input logic [7:0] o,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        longint sa, sb;
        sh = a[4:0];
        sa = $signed(a);
        sb = $signed(b);
        if (s == S_LOGIC) begin
            if (o == O_OR)  return a | b;
            if (o == O_AND) return a & b;
            if (o == O_XOR) return a ^ b;
            if (o == O_NOR) return ~(a | b);
        end else if (s == S_SHIFT) begin
            if (o == O_SLL) return b << sh;
            if (o == O_SRL) return b >> sh;
            if (o == O_SRA) return (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        end else if (s == S_ARITH) begin
            if (o == O_ADD || o == O_ADDU) return a + b;
            if (o == O_SUB || o == O_SUBU) return a - b;
            if (o == O_SLT)  return (sa < sb) ? 32'd1 : 32'd0;
            if (o == O_SLTU) return (a < b) ? 32'd1 : 32'd0;
        end
        return 32'd0;
    endfunction

    // True mathematical signed overflow of ADD/SUB
    function automatic logic ref_ovf(input logic [2:0] s, input logic [7:0] o,
                                     input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        if (s != S_ARITH) return 1'b0;
        if (o == O_ADD) r = sa + sb;
        else if (o == O_SUB) r = sa - sb;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic ref_wr_en(input logic [2:0] s, input logic [7:0] o,
                                       input logic [31:0] a, input logic [31:0] b, input logic en);
`ifdef OVERFLOW_TRAP_EN
        return en & ~ref_ovf(s, o, a, b);
`else
        return en;
`endif
    endfunction

    task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sgn) begin
            sa = $signed(a); sb = $signed(b);
            lq = sa / sb; lr = sa % sb;
            q = lq[31:0]; r = lr[31:0];
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        drive(S_ARITH, O_ADDU, 32'd5, 32'd6, 5'd7, 1'b1);
        tick(); tick();
        n_checks++; if (ex_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", ex_wr_en); else n_pass++;
        n_checks++; if (ex_wr_data !== 32'd0) $display("FAIL reset_wr_data: got %h expected 0", ex_wr_data); else n_pass++;
        n_checks++; if (ex_wr_addr !== 5'd0) $display("FAIL reset_wr_addr: got %h expected 0", ex_wr_addr); else n_pass++;
        n_checks++; if ({ex_hilo_we, ex_hi, ex_lo} !== 65'd0) $display("FAIL reset_hilo: got %b/%h/%h expected 0", ex_hilo_we, ex_hi, ex_lo); else n_pass++;
        drive(S_DIV, O_DIV, 32'd100, 32'd3, 5'd1, 1'b1);
        #1;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall_req); else n_pass++;
        drive(S_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        // Reset in the middle of a divide abandons it
        drive(S_DIV, O_DIVU, 32'd1000, 32'd3, 5'd2, 1'b1);
        #1;
        n_checks++; if (stall_req !== 1'b1) $display("FAIL div_start_stall: got %b expected 1", stall_req); else n_pass++;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL reset_mid_div_stall: got %b expected 0", stall_req); else n_pass++;
        tick();
        reset = 1'b0;
        drive(S_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (ex_hilo_we !== 1'b0 || stall_req !== 1'b0) seen++;
            end
            n_checks++; if (seen !== 0) $display("FAIL reset_mid_div_quiet: got %0d active cycles expected 0", seen); else n_pass++;
        end
    endtask

    task automatic test_directed_alu();
        logic [2:0]  s[12]  = '{S_LOGIC, S_SHIFT, S_ARITH, S_ARITH, S_ARITH, S_SHIFT,
                                S_SHIFT, S_LOGIC, S_LOGIC, S_NOP,   S_ARITH, S_ARITH};
        logic [7:0]  o[12]  = '{O_OR, O_SRA, O_SLT, O_SLTU, O_ADD, O_SLL,
                                O_SRL, O_NOR, 8'h00, 8'h25, O_SUB, O_SUBU};
        logic [31:0] a[12]  = '{32'hF0F0_0000, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd8,
                                32'd4, 32'd0, 32'd1, 32'd9, 32'h8000_0000, 32'd0};
        logic [31:0] b[12]  = '{32'h0000_0F0F, 32'h8000_0010, 32'd1, 32'd1, 32'd1, 32'h0000_00FF,
                                32'h8000_0010, 32'd0, 32'd2, 32'd9, 32'd1, 32'd1};
        logic [31:0] ed[12] = '{32'hF0F0_0F0F, 32'hF800_0001, 32'd1, 32'd0, 32'h8000_0000, 32'h0000_FF00,
                                32'h0800_0001, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
`ifdef OVERFLOW_TRAP_EN
        logic        ee[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        eo[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        logic        ee[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 12; i++) begin
            logic [4:0] ad;
            ad = 5'(i + 3);
            drive(s[i], o[i], a[i], b[i], ad, 1'b1);
            #1;
            n_checks++; if (stall_req !== 1'b0) $display("FAIL dir%0d_stall: got %b expected 0", i, stall_req); else n_pass++;
            tick();
            n_checks++; if (ex_wr_data !== ed[i]) $display("FAIL dir%0d_data: got %h expected %h", i, ex_wr_data, ed[i]); else n_pass++;
            n_checks++; if (ex_wr_en !== ee[i]) $display("FAIL dir%0d_wr_en: got %b expected %b", i, ex_wr_en, ee[i]); else n_pass++;
            n_checks++; if (ex_wr_addr !== ad) $display("FAIL dir%0d_addr: got %h expected %h", i, ex_wr_addr, ad); else n_pass++;
            n_checks++; if (ex_hilo_we !== 1'b0) $display("FAIL dir%0d_hilo_we: got %b expected 0", i, ex_hilo_we); else n_pass++;
`ifdef OVERFLOW_TRAP_EN
            n_checks++; if (ex_ovf !== eo[i]) $display("FAIL dir%0d_ovf: got %b expected %b", i, ex_ovf, eo[i]); else n_pass++;
`endif
        end
    endtask

    task automatic test_random_alu();
        logic [2:0]  ts[13] = '{S_LOGIC, S_LOGIC, S_LOGIC, S_LOGIC, S_SHIFT, S_SHIFT, S_SHIFT,
                                S_ARITH, S_ARITH, S_ARITH, S_ARITH, S_ARITH, S_ARITH};
        logic [7:0]  to[13] = '{O_OR, O_AND, O_XOR, O_NOR, O_SLL, O_SRL, O_SRA,
                                O_ADD, O_ADDU, O_SUB, O_SUBU, O_SLT, O_SLTU};
        logic [31:0] edge_v[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1};
        for (int i = 0; i < 80; i++) begin
            logic [2:0] s; logic [7:0] o; logic [31:0] a, b, ed; logic [4:0] ad; logic en, ee;
            int k;
            k = $urandom_range(0, 15);
            if (k < 13) begin
                s = ts[k]; o = to[k];
            end else begin
                s = 3'($urandom_range(0, 7));
                if (s == S_DIV) s = 3'b011;
                o = 8'($urandom);
            end
            a  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
            ad = 5'($urandom);
            en = 1'($urandom);
            drive(s, o, a, b, ad, en);
            ed = ref_alu(s, o, a, b);
            ee = ref_wr_en(s, o, a, b, en);
            tick();
            n_checks++; if (ex_wr_data !== ed) $display("FAIL rnd%0d_data sel=%b op=%h a=%h b=%h: got %h expected %h", i, s, o, a, b, ex_wr_data, ed); else n_pass++;
            n_checks++; if (ex_wr_en !== ee) $display("FAIL rnd%0d_wr_en: got %b expected %b", i, ex_wr_en, ee); else n_pass++;
            n_checks++; if (ex_wr_addr !== ad) $display("FAIL rnd%0d_addr: got %h expected %h", i, ex_wr_addr, ad); else n_pass++;
            n_checks++; if (ex_hilo_we !== 1'b0) $display("FAIL rnd%0d_hilo_we: got %b expected 0", i, ex_hilo_we); else n_pass++;
`ifdef OVERFLOW_TRAP_EN
            n_checks++; if (ex_ovf !== ref_ovf(s, o, a, b)) $display("FAIL rnd%0d_ovf: got %b expected %b", i, ex_ovf, ref_ovf(s, o, a, b)); else n_pass++;
`endif
        end
    endtask

    // Divides issued back to back (next starts the cycle after the result),
    // with operands scrambled while BUSY to show they are latched.
    task automatic test_div();
        logic        ds[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] da[5] = '{32'hFFFF_FFF9, 32'h0000_1234, 32'h8000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF};
        logic [31:0] db[5] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1};
        logic [31:0] dq[5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] dr[5] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'd0, 32'hFFFF_FF00, 32'd0};
        for (int i = 0; i < 17; i++) begin
            logic sg; logic [31:0] a, b, eq, er;
            int cyc, lat, bad;
            if (i < 5) begin
                sg = ds[i]; a = da[i]; b = db[i]; eq = dq[i]; er = dr[i];
            end else begin
                sg = 1'($urandom);
                a  = $urandom;
                b  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                ref_div(sg, a, b, eq, er);
            end
            lat = (b == 32'd0) ? 1 : 33;
            drive(S_DIV, sg ? O_DIV : O_DIVU, a, b, 5'($urandom), 1'b1);
            #2;
            cyc = 0; bad = 0;
            while (stall_req === 1'b1 && cyc < 40) begin
                @(posedge clk); #1;
                if (ex_hilo_we !== 1'b0 || ex_wr_en !== 1'b0 || ex_wr_data !== 32'd0) bad++;
                if (cyc > 0 && cyc < 30) begin
                    src_data1 = $urandom; src_data2 = $urandom;
                end
                #2;
                cyc++;
            end
            n_checks++; if (cyc !== lat) $display("FAIL div%0d_stall_cycles: got %0d expected %0d", i, cyc, lat); else n_pass++;
            n_checks++; if (bad !== 0) $display("FAIL div%0d_bubble: got %0d bad cycles expected 0", i, bad); else n_pass++;
            tick();
            drive(S_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
            n_checks++; if (ex_lo !== eq) $display("FAIL div%0d_lo a=%h b=%h s=%b: got %h expected %h", i, a, b, sg, ex_lo, eq); else n_pass++;
            n_checks++; if (ex_hi !== er) $display("FAIL div%0d_hi a=%h b=%h s=%b: got %h expected %h", i, a, b, sg, ex_hi, er); else n_pass++;
            n_checks++; if (ex_hilo_we !== 1'b1) $display("FAIL div%0d_hilo_we: got %b expected 1", i, ex_hilo_we); else n_pass++;
            n_checks++; if (ex_wr_en !== 1'b0 || ex_wr_data !== 32'd0) $display("FAIL div%0d_wr: got %b/%h expected 0/0", i, ex_wr_en, ex_wr_data); else n_pass++;
        end
        tick();
        n_checks++; if (ex_hilo_we !== 1'b0) $display("FAIL div_after_nop_hilo: got %b expected 0", ex_hilo_we); else n_pass++;
    endtask

    task automatic test_flush_abort();
        int seen;
        drive(S_DIV, O_DIV, 32'd100, 32'd7, 5'd4, 1'b1);
        #1;
        n_checks++; if (stall_req !== 1'b1) $display("FAIL abort_start_stall: got %b expected 1", stall_req); else n_pass++;
        repeat (11) tick();   // now in BUSY with counter at 10
        flush = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL abort_flush_stall: got %b expected 0", stall_req); else n_pass++;
        tick();
        flush = 1'b0;
        n_checks++; if (ex_wr_en !== 1'b0 || ex_hilo_we !== 1'b0 || ex_wr_data !== 32'd0) $display("FAIL abort_bubble: got %b/%b/%h expected 0/0/0", ex_wr_en, ex_hilo_we, ex_wr_data); else n_pass++;
        drive(S_ARITH, O_ADDU, 32'd1234, 32'd4321, 5'd9, 1'b1);
        #1;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL abort_addu_stall: got %b expected 0", stall_req); else n_pass++;
        tick();
        n_checks++; if (ex_wr_data !== 32'd5555 || ex_wr_en !== 1'b1 || ex_wr_addr !== 5'd9) $display("FAIL abort_addu: got %h/%b/%h expected 000015b3/1/09", ex_wr_data, ex_wr_en, ex_wr_addr); else n_pass++;
        drive(S_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        seen = 0;
        for (int c = 0; c < 36; c++) begin
            tick();
            if (ex_hilo_we !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL abort_no_hilo: got %0d writes expected 0", seen); else n_pass++;
        // Flush in the DONE cycle of a divide-by-zero suppresses the HI/LO write
        drive(S_DIV, O_DIVU, 32'h55, 32'd0, 5'd1, 1'b1);
        tick();
        flush = 1'b1;
        #1;
        n_checks++; if (stall_req !== 1'b0) $display("FAIL flush_done_stall: got %b expected 0", stall_req); else n_pass++;
        tick();
        flush = 1'b0;
        drive(S_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        n_checks++; if (ex_hilo_we !== 1'b0 || ex_lo !== 32'd0) $display("FAIL flush_done_hilo: got %b/%h expected 0/0", ex_hilo_we, ex_lo); else n_pass++;
        tick();
        n_checks++; if (ex_hilo_we !== 1'b0) $display("FAIL flush_done_later: got %b expected 0", ex_hilo_we); else n_pass++;
        // Flush on a plain ALU op annuls it
        drive(S_LOGIC, O_OR, 32'hFF, 32'h100, 5'd6, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (ex_wr_en !== 1'b0 || ex_wr_data !== 32'd0) $display("FAIL flush_alu: got %b/%h expected 0/0", ex_wr_en, ex_wr_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        drive(S_LOGIC, O_XOR, 32'hA5A5_0000, 32'h0000_5A5A, 5'd12, 1'b1);
        tick();
        n_checks++; if (ex_wr_data !== 32'hA5A5_5A5A || ex_wr_en !== 1'b1) $display("FAIL b2b_xor: got %h/%b expected a5a55a5a/1", ex_wr_data, ex_wr_en); else n_pass++;
        drive(S_DIV, O_DIVU, 32'd100, 32'd7, 5'd13, 1'b1);
        #1;
        cyc = 0;
        while (stall_req === 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_checks++; if (cyc !== 33) $display("FAIL b2b_div_stall: got %0d expected 33", cyc); else n_pass++;
        tick();
        drive(S_ARITH, O_SUBU, 32'd10, 32'd3, 5'd14, 1'b1);
        n_checks++; if (ex_lo !== 32'd14 || ex_hi !== 32'd2 || ex_hilo_we !== 1'b1) $display("FAIL b2b_div: got %h/%h/%b expected 0000000e/00000002/1", ex_lo, ex_hi, ex_hilo_we); else n_pass++;
        tick();
        n_checks++; if (ex_wr_data !== 32'd7 || ex_wr_addr !== 5'd14 || ex_hilo_we !== 1'b0) $display("FAIL b2b_subu: got %h/%h/%b expected 00000007/0e/0", ex_wr_data, ex_wr_addr, ex_hilo_we); else n_pass++;
        drive(S_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        drive(S_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        test_reset();
        test_directed_alu();
        test_random_alu();
        test_div();
        test_flush_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_stage_div.md
Name: ex_stage_div

Overview:
- Execute stage that consumes the ID/EX pipeline buffer outputs: alu_sel, alu_op, src_data1, src_data2, wr_addr and wr_en.
- Performs logic, shift and arithmetic operations in a single cycle.
- Performs DIV and DIVU with an iterative 32-step divider. While the divider runs, the block requests a pipeline stall.
- Results go to a registered EX/MEM output bank that feeds the memory stage and forwarding logic.

Parameters:
- DATA_W, 32, operand and result width. Only 32 is supported.
- ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alu_sel  in  3  operation class: 000 NOP, 001 LOGIC, 010 SHIFT, 100 ARITH, 110 DIV
- alu_op  in  8  operation code within the class
- src_data1  in  32  operand A (shift amount in [4:0] for SHIFT)
- src_data2  in  32  operand B (data to shift for SHIFT)
- wr_addr  in  5  destination register
- wr_en  in  1  destination write enable
- flush  in  1  annul the current instruction and abort any divide
- stall_req  out  1  high while a divide is occupying the stage; upstream holds its inputs
- ex_wr_addr  out  5  registered destination
- ex_wr_en  out  1  registered write enable
- ex_wr_data  out  32  registered result
- ex_hilo_we  out  1  registered HI/LO write strobe
- ex_hi  out  32  registered remainder
- ex_lo  out  32  registered quotient
- ex_ovf  out  1  registered overflow flag; only present with the optional feature

Behaviour:
- Reset: all ex_* outputs are 0, the FSM is IDLE, stall_req is 0. Reset overrides flush and divider state.
- alu_op codes:
  - LOGIC: OR 0x25, AND 0x24, XOR 0x26, NOR 0x27.
  - SHIFT: SLL 0x7C, SRL 0x02, SRA 0x03.
  - ARITH: ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, SLT 0x2A, SLTU 0x2B.
  - DIV: DIV 0x1A, DIVU 0x1B.
- Unknown (alu_sel, alu_op) pairs produce wr_data 0 but still pass wr_en through.
- Non-DIV classes: one-cycle latency. The result, wr_addr and wr_en are registered on the next edge; ex_hilo_we is 0.
- Arithmetic rules:
  - ADD/SUB/ADDU/SUBU are 32-bit wrap-around.
  - SLT is a signed compare, SLTU an unsigned compare. The result is 0 or 1.
  - SRA sign-fills from bit 31.
- FSM states:
  - IDLE:
    - With alu_sel=DIV and flush=0: stall_req is 1 combinationally.
    - If src_data2 is 0, the next state is DONE with quotient 0xFFFFFFFF and remainder = src_data1.
    - Otherwise the next state is BUSY, with magnitudes latched and the counter at 0.
  - BUSY:
    - stall_req is 1.
    - One restoring shift-subtract step per cycle.
    - After the counter reaches 31, the next state is DONE.
  - DONE:
    - stall_req is 0.
    - The output register captures ex_lo = quotient and ex_hi = remainder, with ex_hilo_we=1, ex_wr_en=0 and ex_wr_data=0.
    - The next state is IDLE.
- Divide latency: a divide presented in cycle T holds stall_req high for cycles T..T+32. The result is registered at the end of T+33, the same edge on which upstream advances.
- Signed DIV:
  - Divide magnitudes.
  - Negate the quotient if the operand signs differ.
  - The remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- Output register while stall_req=1: a bubble is captured (ex_wr_en=0, ex_hilo_we=0, data 0).
- flush=1 in any cycle:
  - The FSM returns to IDLE next edge.
  - stall_req drops in the same cycle.
  - A bubble is captured.
  - flush wins over DONE, so no HI/LO write occurs.
- Divider inputs are latched on IDLE->BUSY. Upstream changes during BUSY are ignored.

Optional Feature:
- Macro OVERFLOW_TRAP_EN.
- Defined:
  - Signed ADD/SUB overflow forces ex_wr_en=0 and ex_ovf=1 for that instruction.
  - Overflow is detected when the operand signs are equal for ADD, or differ for SUB, and the result sign differs from operand A.
- Undefined: the ex_ovf port is absent and ADD/SUB behave as ADDU/SUBU.

Decomposition:
- Shared package ex_pkg holds:
  - the alu_sel class constants;
  - the alu_op code constants;
  - the FSM state enum (IDLE, BUSY, DONE);
  - the DATA_W/ADDR_W constants.
- One sub-module, div_iter: it owns the FSM, the counter, and the dividend/divisor/quotient registers with sign fix-up.
- The ALU and output register stay in ex_stage_div.

Test Plan:
- OR: src1=0xF0F0_0000, src2=0x0000_0F0F, wr_addr=3, wr_en=1 -> next cycle ex_wr_data=0xF0F0_0F0F, ex_wr_addr=3, ex_wr_en=1.
- SRA: src1=4, src2=0x8000_0010 -> ex_wr_data=0xF800_0001. SLT with src1=-1, src2=1 -> 1; SLTU with the same operands -> 0.
- DIV: src1=-7, src2=2 at cycle T -> stall_req high for T..T+32, then ex_lo=0xFFFF_FFFD, ex_hi=0xFFFF_FFFF, ex_hilo_we=1 after the T+33 edge.
- DIVU by zero: src1=0x1234, src2=0 -> stall_req high in cycle T only, then ex_lo=0xFFFF_FFFF, ex_hi=0x1234.
- Abort: flush during BUSY at counter=10 -> stall_req=0 in that cycle, bubble captured, ex_hilo_we never asserted. A following ADDU executes normally.
- OVERFLOW_TRAP_EN: ADD 0x7FFF_FFFF+1 -> ex_ovf=1, ex_wr_en=0. Without the macro -> ex_wr_data=0x8000_0000, ex_wr_en=1.
